perf_counter_dump: RTL
======================

// Module: perf_counter_dump
// PURPOSE
//  Reader side of the performance-counter block: snapshots the seven 32-bit totals atomically,
//  then streams them out one word per beat over a valid/ready interface.
//  Feeds the debug UART/trace path so counters are read off-chip without stalling the pipeline.
//  A dump is triggered by a request pulse or by an optional periodic timer.
// PARAMETERS
//  DATA_W       32  counter/word width
//  DUMP_PERIOD  0   auto-dump interval in cycles; 0 = timer disabled
//  DROP_W       8   width of saturating dropped-trigger counter
// PORTS
//  clk                 in   1       system clock, all logic on posedge
//  rst_n               in   1       asynchronous, active-low reset
//  total_instructions  in   DATA_W  live counter, word 0
//  total_loads         in   DATA_W  word 1
//  total_stores        in   DATA_W  word 2
//  total_alus          in   DATA_W  word 3
//  total_controls      in   DATA_W  word 4
//  total_cycles        in   DATA_W  word 5
//  total_stall_cycles  in   DATA_W  word 6
//  dump_req            in   1       1-cycle trigger pulse
//  out_ready           in   1       sink accepts beat
//  out_valid           out  1       beat present
//  out_data            out  DATA_W  beat payload
//  out_index           out  3       word index 0..6 (7 = checksum)
//  out_last            out  1       final beat of dump
//  busy                out  1       dump in progress (state SEND)
//  drop_count          out  DROP_W  triggers lost while busy, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; out_valid/out_last/busy=0; out_data/out_index=0;
//   drop_count, snapshot regs, timer=0. Reset mid-dump aborts at once; no partial beat resumes.
//  trigger = dump_req | tick. tick: when DUMP_PERIOD>0, timer counts 0..DUMP_PERIOD-1 every cycle
//   (all states), tick=1 in the cycle timer==DUMP_PERIOD-1, then wraps to 0.
//  dump_req and tick in the same cycle = one trigger (no drop).
//  FSM IDLE: trigger at edge k -> all seven inputs captured at edge k (same edge, atomic);
//   state SEND, out_valid=1, out_index=0, out_data=snapshot word 0 visible after edge k.
//  FSM SEND: beat accepted when out_valid&&out_ready; next edge presents next index.
//   out_data/out_index/out_last held stable while out_valid&&!out_ready.
//   out_last=1 only with the final index. Final beat accepted -> IDLE, out_valid=0 next cycle.
//   Minimum dump = 7 cycles (8 with checksum) at out_ready=1; new dump earliest 1 cycle later.
//  Any trigger while state==SEND (incl. the final-handshake cycle) is dropped:
//   drop_count+=1, saturating at 2^DROP_W-1; cleared only by reset.
//  Live inputs changing during SEND never affect streamed data.
// CONFIGURATION
//  PERF_DUMP_CHECKSUM_EN defined: 8th beat, out_index=7, out_data = XOR of the 7 snapshot
//   words, out_last on index 7.
//  Not defined: 7 beats, out_last on index 6; index 7 never emitted.
// STRUCTURE
//  perf_defs.vh (shared include): word-index localparams IDX_INSTR..IDX_STALL, IDX_CSUM,
//   FSM state encodings ST_IDLE/ST_SEND.
//  Sub-module perf_dump_timer: period counter + tick, tied off when DUMP_PERIOD=0.
//  Top: snapshot regs, FSM, output mux, drop counter.
// TESTING
//  1 inputs 10,2,3,4,1,20,5; dump_req, out_ready=1 -> beats idx0..6 = 10,2,3,4,1,20,5
//    on consecutive cycles, out_last only on idx6, busy low next cycle.
//  2 out_ready=0 for 4 cycles at idx2 -> out_data=3, out_index=2 held stable;
//    inputs changed mid-dump -> streamed values remain the snapshot.
//  3 dump_req pulsed 3x during SEND -> drop_count=3; 300 drops with DROP_W=8 -> 255.
//  4 DUMP_PERIOD=16, no dump_req -> dumps start 16 cycles apart; dump_req coincident
//    with tick -> one dump, drop_count unchanged.
//  5 rst_n low at idx4 -> out_valid=0 immediately; after release, dump_req -> restarts idx0.
//  6 PERF_DUMP_CHECKSUM_EN, inputs 1,2,4,8,16,32,64 -> idx7 data=127, out_last on idx7 only.

Source files
------------

// File: rtl/perf_counter_dump_pkg.sv
// Shared definitions for the performance-counter dump block:
// beat indices, FSM state encoding and word count.
package perf_counter_dump_pkg;

  localparam int NUM_CNT = 7;

  localparam logic [2:0] IDX_INSTR = 3'd0;
  localparam logic [2:0] IDX_LOAD  = 3'd1;
  localparam logic [2:0] IDX_STORE = 3'd2;
  localparam logic [2:0] IDX_ALU   = 3'd3;
  localparam logic [2:0] IDX_CTRL  = 3'd4;
  localparam logic [2:0] IDX_CYCLE = 3'd5;
  localparam logic [2:0] IDX_STALL = 3'd6;
  localparam logic [2:0] IDX_CSUM  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } dump_state_e;

endpackage

// File: rtl/perf_dump_timer.sv
// Free-running period counter for the automatic dump trigger; tick is high
// in the last cycle of every DUMP_PERIOD-cycle window.
module perf_dump_timer #(
  parameter int DUMP_PERIOD = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int TW = (DUMP_PERIOD > 1) ? $clog2(DUMP_PERIOD) : 1;
  localparam logic [TW-1:0] LAST_CNT = TW'(DUMP_PERIOD - 1);

  logic [TW-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  assign tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/perf_counter_dump.sv
// Atomic snapshot of the seven performance totals, streamed one word per
// valid/ready beat. Define PERF_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module perf_counter_dump
  import perf_counter_dump_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DUMP_PERIOD = 0,
  parameter int DROP_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] total_instructions,
  input  logic [DATA_W-1:0] total_loads,
  input  logic [DATA_W-1:0] total_stores,
  input  logic [DATA_W-1:0] total_alus,
  input  logic [DATA_W-1:0] total_controls,
  input  logic [DATA_W-1:0] total_cycles,
  input  logic [DATA_W-1:0] total_stall_cycles,
  input  logic              dump_req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_index,
  output logic              out_last,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count
);

`ifdef PERF_DUMP_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = IDX_CSUM;
`else
  localparam logic [2:0] LAST_IDX = IDX_STALL;
`endif

  dump_state_e       state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] snap_q [NUM_CNT];
  logic [DATA_W-1:0] live_w [NUM_CNT];
  logic [DATA_W-1:0] word;
  logic [DROP_W-1:0] drop_q;
  logic              tick;
  logic              trigger;
  logic              capture;
  logic              sending;

  generate
    if (DUMP_PERIOD > 0) begin : g_timer
      perf_dump_timer #(
        .DUMP_PERIOD(DUMP_PERIOD)
      ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
      );
    end else begin : g_no_timer
      assign tick = 1'b0;
    end
  endgenerate

  assign trigger = dump_req | tick;
  assign sending = (state_q == ST_SEND);

  assign live_w[IDX_INSTR] = total_instructions;
  assign live_w[IDX_LOAD]  = total_loads;
  assign live_w[IDX_STORE] = total_stores;
  assign live_w[IDX_ALU]   = total_alus;
  assign live_w[IDX_CTRL]  = total_controls;
  assign live_w[IDX_CYCLE] = total_cycles;
  assign live_w[IDX_STALL] = total_stall_cycles;

  // NOTE: every combinational output gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_SEND;
          idx_d   = IDX_INSTR;
          capture = 1'b1;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = IDX_INSTR;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = IDX_INSTR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_INSTR;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset to
  // give a defined out_data after reset; a real memory would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        snap_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        snap_q[i] <= live_w[i];
      end
    end
  end

  // Triggers that land while a dump is streaming are counted, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (sending && trigger && (drop_q != {DROP_W{1'b1}})) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

`ifdef PERF_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      csum = csum ^ snap_q[i];
    end
  end
`endif

  always_comb begin
    word = '0;
    unique case (idx_q)
      IDX_INSTR: word = snap_q[IDX_INSTR];
      IDX_LOAD:  word = snap_q[IDX_LOAD];
      IDX_STORE: word = snap_q[IDX_STORE];
      IDX_ALU:   word = snap_q[IDX_ALU];
      IDX_CTRL:  word = snap_q[IDX_CTRL];
      IDX_CYCLE: word = snap_q[IDX_CYCLE];
      IDX_STALL: word = snap_q[IDX_STALL];
`ifdef PERF_DUMP_CHECKSUM_EN
      IDX_CSUM:  word = csum;
`endif
      default:   word = '0;
    endcase
  end

  assign out_valid  = sending;
  assign busy       = sending;
  assign out_index  = idx_q;
  assign out_data   = sending ? word : '0;
  assign out_last   = sending && (idx_q == LAST_IDX);
  assign drop_count = drop_q;

endmodule
